// File: rtl/fir_pkg.sv
// Shared sizing constants and FSM state encoding for the FIR tap sequencer.
package fir_pkg;

  localparam int TAPS = 64;
  localparam int AW   = 6;
  localparam int DW   = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fir_state_e;

endpackage

// File: rtl/fir_sample_ring.sv
// Sample delay line: register array cleared on reset, one synchronous write
// port and one combinational read port.
module fir_sample_ring
  import fir_pkg::*;
#(
  parameter int DEPTH = TAPS,
  parameter int IW    = AW,
  parameter int W     = DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [IW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Storage array; reset clears all history so a cold start sees zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Accepts one sample at a time into the delay line and streams the 64
// (x[n-k], h[k]) pairs for that sample to the downstream MAC.
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic [AW-1:0] coef_addr,
  input  logic [DW-1:0] coef_q,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_sample,
  output logic [DW-1:0] m_coef,
  output logic          m_first,
  output logic          m_last,
  output logic          busy
);

  fir_state_e    state_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] base_r;
  logic [AW-1:0] k_r;

  logic          accept_s;
  logic          beat_s;
  logic [AW-1:0] rd_addr_s;
  logic [DW-1:0] ring_q_s;

  assign s_ready   = (state_r == IDLE);
  assign busy      = (state_r == RUN);
  assign coef_addr = k_r;
  assign accept_s  = s_valid & s_ready;
  assign beat_s    = m_valid & m_ready;
  // Tap k reads the sample written k accepts ago; AW-bit wrap is the modulo.
  assign rd_addr_s = base_r - k_r;

  fir_sample_ring #(
    .DEPTH (TAPS),
    .IW    (AW),
    .W     (DW)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .we    (accept_s),
    .waddr (wr_ptr_r),
    .wdata (s_data),
    .raddr (rd_addr_s),
    .rdata (ring_q_s)
  );

  // Sequencer FSM with all stream outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      wr_ptr_r <= {AW{1'b0}};
      base_r   <= {AW{1'b0}};
      k_r      <= {AW{1'b0}};
      m_valid  <= 1'b0;
      m_sample <= {DW{1'b0}};
      m_coef   <= {DW{1'b0}};
      m_first  <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // Tap 0 bypasses the ring: the new sample is still being written.
            base_r   <= wr_ptr_r;
            wr_ptr_r <= wr_ptr_r + AW'(1);
            m_valid  <= 1'b1;
            m_sample <= s_data;
            m_coef   <= coef_q;
            m_first  <= 1'b1;
            m_last   <= 1'b0;
            k_r      <= AW'(1);
            state_r  <= RUN;
          end
        end
        RUN: begin
          if (beat_s) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_first <= 1'b0;
              m_last  <= 1'b0;
              k_r     <= {AW{1'b0}};
              state_r <= IDLE;
            end else begin
              m_sample <= ring_q_s;
              m_coef   <= coef_q;
              m_first  <= 1'b0;
              m_last   <= (k_r == AW'(TAPS - 1));
              k_r      <= k_r + AW'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          k_r     <= {AW{1'b0}};
          m_valid <= 1'b0;
          m_first <= 1'b0;
          m_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: table of pushes with hand-computed
// burst samples, plus wrap, stall, input-noise and mid-burst reset sequences.
module tb_fir_tap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [5:0]  coef_addr;
  logic [15:0] coef_q;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_sample;
  logic [15:0] m_coef;
  logic        m_first;
  logic        m_last;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign coef_q = 16'hC000 | {10'd0, coef_addr};

  fir_tap_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .coef_addr (coef_addr),
    .coef_q    (coef_q),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sample  (m_sample),
    .m_coef    (m_coef),
    .m_first   (m_first),
    .m_last    (m_last),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_b0;
    logic [15:0] exp_b1;
    logic [15:0] exp_b63;
    bit          rand_ready;
    bit          noise;
  } vec_t;

  vec_t        tbl [5];
  logic [15:0] hist [$];
  logic [15:0] got_sample [64];
  logic [15:0] got_coef [64];
  logic        got_first [64];
  logic        got_last [64];
  int          got_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
  endtask

  task automatic push(input logic [15:0] din);
    int t = 0;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("push_s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = din;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    hist.push_back(din);
  endtask

  // Record handshaken beats; checks hold-during-stall and s_ready low in RUN.
  task automatic collect(input bit rand_ready, input bit noise, input int max_beats);
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [15:0] hs = 16'h0;
    logic [15:0] hc = 16'h0;
    logic        hf = 1'b0;
    logic        hl = 1'b0;
    got_n = 0;
    while (got_n < max_beats && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_sample", 32'(m_sample), 32'(hs));
        chk("stall_coef", 32'(m_coef), 32'(hc));
        chk("stall_first", 32'(m_first), 32'(hf));
        chk("stall_last", 32'(m_last), 32'(hl));
      end
      m_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
      if (noise) begin
        chk("run_s_ready_low", 32'(s_ready), 32'd0);
        s_valid = !(m_valid && m_ready && m_last);
        s_data  = 16'($urandom);
      end
      stalled = m_valid && !m_ready;
      hs = m_sample; hc = m_coef; hf = m_first; hl = m_last;
      if (m_valid && m_ready) begin
        got_sample[got_n] = m_sample;
        got_coef[got_n]   = m_coef;
        got_first[got_n]  = m_first;
        got_last[got_n]   = m_last;
        got_n++;
      end
    end
    if (got_n < max_beats) chk("burst_timeout", 32'(got_n), 32'(max_beats));
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic check_burst(input string tag);
    logic [15:0] es;
    logic [15:0] ec;
    for (int k = 0; k < 64; k++) begin
      es = (k < hist.size()) ? hist[hist.size() - 1 - k] : 16'h0000;
      ec = 16'hC000 | 16'(k);
      chk($sformatf("%s_sample_k%0d", tag, k), 32'(got_sample[k]), 32'(es));
      chk($sformatf("%s_coef_k%0d", tag, k), 32'(got_coef[k]), 32'(ec));
      chk($sformatf("%s_first_k%0d", tag, k), 32'(got_first[k]), (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_last_k%0d", tag, k), 32'(got_last[k]), (k == 63) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic end_check(input string tag);
    @(negedge clk);
    chk({tag, "_end_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_end_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_end_coef_addr"}, 32'(coef_addr), 32'd0);
  endtask

  initial begin
    tbl[0] = '{16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{16'h4000, 16'h4000, 16'h3C00, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{16'h4200, 16'h4200, 16'h4000, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{16'h4400, 16'h4400, 16'h4200, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h4500, 16'h4500, 16'h4400, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_sample", 32'(m_sample), 32'd0);
    chk("rst_m_coef", 32'(m_coef), 32'd0);
    chk("rst_m_first", 32'(m_first), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_s_ready", 32'(s_ready), 32'd1);
    chk("rel_coef_addr", 32'(coef_addr), 32'd0);

    for (int i = 0; i < 5; i++) begin
      push(tbl[i].din);
      collect(tbl[i].rand_ready, tbl[i].noise, 64);
      chk($sformatf("tbl%0d_b0", i), 32'(got_sample[0]), 32'(tbl[i].exp_b0));
      chk($sformatf("tbl%0d_b1", i), 32'(got_sample[1]), 32'(tbl[i].exp_b1));
      chk($sformatf("tbl%0d_b63", i), 32'(got_sample[63]), 32'(tbl[i].exp_b63));
      check_burst($sformatf("tbl%0d", i));
      end_check($sformatf("tbl%0d", i));
    end

    // 65 pushes of s_data=i: the write pointer wraps and overwrites sample 0.
    do_reset();
    for (int i = 0; i < 65; i++) begin
      push(16'(i));
      collect(1'b0, 1'b0, 64);
      check_burst($sformatf("wrap%0d", i));
    end
    chk("wrap_b0", 32'(got_sample[0]), 32'h0040);
    chk("wrap_b1", 32'(got_sample[1]), 32'h003F);
    chk("wrap_b63", 32'(got_sample[63]), 32'h0001);
    end_check("wrap");

    // Reset in the middle of a burst abandons it and clears history.
    push(16'h5555);
    collect(1'b0, 1'b0, 20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    chk("midrst_m_sample", 32'(m_sample), 32'd0);
    rst = 1'b0;
    hist.delete();
    push(16'h1234);
    collect(1'b0, 1'b0, 64);
    chk("postrst_b0", 32'(got_sample[0]), 32'h1234);
    chk("postrst_b1", 32'(got_sample[1]), 32'h0000);
    chk("postrst_b63", 32'(got_sample[63]), 32'h0000);
    check_burst("postrst");
    end_check("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Consumer/driver stage for the FP16 FIR coefficient ROM (data_cmem_fp16, 64 taps, combinational read).
- Accepts one FP16 input sample per valid/ready beat and stores it in a 64-entry sample delay line.
- For each accepted sample, issues 64 (sample, coefficient) pairs to the downstream FP16 MAC, tap 0 first, over a valid/ready stream with first/last markers.
- Does no arithmetic on data; it only sequences addresses and moves data.

Parameters:
- TAPS, 64, number of taps; power of two, equal to ROM depth.
- AW, 6, address width, log2(TAPS).
- DW, 16, sample/coefficient width (FP16 bit patterns, passed opaque).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample ready.
- s_data  in  DW  input sample.
- coef_addr  out  AW  ROM address, driven to data_cmem_fp16 a.
- coef_q  in  DW  ROM data, combinational from coef_addr.
- m_valid  out  1  tap pair valid.
- m_ready  in  1  MAC ready.
- m_sample  out  DW  delayed sample x[n-k].
- m_coef  out  DW  coefficient h[k].
- m_first  out  1  high on tap k=0 beat.
- m_last  out  1  high on tap k=TAPS-1 beat.
- busy  out  1  high while in RUN.

Behaviour:
- Reset values: state IDLE, wr_ptr=0, base=0, k=0, all delay-line entries 0, m_valid=0, m_sample=0, m_coef=0, m_first=0, m_last=0, busy=0. s_ready=1 and coef_addr=0 once reset is released.
- Combinational outputs:
  - s_ready = (state==IDLE).
  - busy = (state==RUN).
  - coef_addr = k (k is held at 0 in IDLE).
- IDLE, on s_valid & s_ready (accept):
  - ring[wr_ptr] <= s_data; base <= wr_ptr; wr_ptr <= wr_ptr+1 (mod TAPS, 63 wraps to 0).
  - m_valid<=1, m_sample<=s_data (bypass, no ring read), m_coef<=coef_q (addr 0), m_first<=1, m_last<=0, k<=1, state<=RUN.
  - Latency: tap 0 is visible on m_* the cycle after accept.
- RUN, load condition is m_valid & m_ready (beat consumed):
  - If m_last is currently 1: m_valid<=0, m_first<=0, m_last<=0, k<=0, state<=IDLE. s_ready rises the following cycle.
  - Otherwise: m_sample<=ring[(base-k) mod TAPS], m_coef<=coef_q, m_first<=0, m_last<=(k==TAPS-1), k<=k+1 (AW-bit wrap, next value ignored after last).
- Stall: when m_ready=0 and m_valid=1, all m_* outputs and k hold.
- Throughput: with m_ready tied high, 64 back-to-back beats with no bubbles; minimum sample period is 65 cycles (accept cycle plus 64 beats).
- In RUN, s_valid is ignored (s_ready=0); no sample is lost or overwritten.
- History: entries never written are 0, so the first outputs after reset see zero history (FIR cold start).
- Index arithmetic: AW-bit unsigned subtraction; wrap is implicit.
- Reset asserted mid-sequence: immediately IDLE with all values above; the partial tap stream is abandoned and the delay line is cleared.
- m_ready asserted while m_valid=0 has no effect.

Decomposition:
- Package fir_pkg: TAPS, AW, DW defaults and the state enum {IDLE, RUN}.
- Sub-module fir_sample_ring: TAPS x DW register array, async clear on rst, one synchronous write port, one combinational read port.

Test Plan:
- Bench ROM model is q = 16'hC000 | addr; m_ready tied 1.
  - Reset, push s_data=16'h3C00 -> 64 beats.
  - Beat 0: m_sample=3C00, m_coef=C000, m_first=1.
  - Beats 1..63: m_sample=0000, m_coef=C000+k.
  - Beat 63: m_last=1, m_coef=C03F; s_ready=1 the following cycle.
- Push 3C00, then 4000 -> second burst: beat0 m_sample=4000, beat1 m_sample=3C00, beats 2..63 m_sample=0000.
- Push 65 samples with s_data=i -> 65th burst beat k has m_sample=64-k; beat 63 has m_sample=0001 (wr_ptr wrap checked).
- Random m_ready with 30% low -> m_* stable while m_valid&!m_ready; exactly 64 handshakes per sample with an identical sequence to the no-stall run.
- Hold s_valid=1 with changing s_data during RUN -> s_ready=0 throughout; only the value present on the accept cycle is stored.
- Assert rst at beat 20 -> next cycle m_valid=0, busy=0, s_ready=1; a following push gives m_sample=0000 on beats 1..63.
